// File: rtl/lsu_core.sv
// Load/store unit: registered, handshaked data-memory port with byte lanes,
// load extension and misalignment/bus-error reporting. One access in flight.
module lsu_core #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32,
  localparam int OFF_W  = $clog2(XLEN/8),
  localparam int STRB_W = XLEN/8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_wen_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_signed_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [XLEN-1:0]   req_wdata_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [XLEN-1:0]   resp_rdata_o,
  output logic              resp_err_o,
  output logic              mem_req_valid_o,
  input  logic              mem_req_ready_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [XLEN-1:0]   mem_wdata_o,
  output logic [STRB_W-1:0] mem_wstrb_o,
  input  logic              mem_rsp_valid_i,
  input  logic [XLEN-1:0]   mem_rsp_data_i,
  input  logic              mem_rsp_err_i,
  output logic [1:0]        state_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both 1; valid and its payload stay stable until then. mem_rsp has no ready.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]        state_q, state_d;
  logic              wen_q, signed_q, err_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]   wdata_q, rdata_q;

  logic            accept, misalign, illegal, rsp_take, sign_bit;
  logic [XLEN-1:0] rsp_shift, load_ext, rsp_rdata;
  int              nbits, off, nbytes;

  assign req_ready_o     = (state_q == S_IDLE) && rst_ni;
  assign accept          = req_valid_i && req_ready_o;
  assign rsp_take        = (state_q == S_WAIT) && mem_rsp_valid_i;
  assign resp_valid_o    = (state_q == S_RESP);
  assign mem_req_valid_o = (state_q == S_REQ);
  assign resp_rdata_o    = rdata_q;
  assign resp_err_o      = err_q;
  assign mem_we_o        = wen_q;
  assign mem_addr_o      = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign mem_wdata_o     = wdata_q << {addr_q[OFF_W-1:0], 3'b000};
  assign state_o         = state_q;

  always_comb begin
    case (req_size_i)
      2'd0:    misalign = 1'b0;
      2'd1:    misalign = req_addr_i[0];
      2'd2:    misalign = |req_addr_i[1:0];
      default: misalign = |req_addr_i[2:0];
    endcase
    illegal = misalign || ((req_size_i == 2'd3) && (XLEN < 64));
  end

  always_comb begin
    off    = int'(addr_q[OFF_W-1:0]);
    nbytes = 1 << size_q;
    for (int i = 0; i < STRB_W; i++) begin
      mem_wstrb_o[i] = wen_q && (i >= off) && (i < off + nbytes);
    end
  end

  // Load path: bring the addressed lanes down to bit 0, then extend above
  // the access width with either the access's top bit or zero.
  always_comb begin
    rsp_shift = mem_rsp_data_i >> {addr_q[OFF_W-1:0], 3'b000};
    nbits     = 8 << size_q;
    case (size_q)
      2'd0:    sign_bit = signed_q & rsp_shift[7];
      2'd1:    sign_bit = signed_q & rsp_shift[15];
      2'd2:    sign_bit = signed_q & rsp_shift[31];
      default: sign_bit = signed_q & rsp_shift[XLEN-1];
    endcase
    for (int i = 0; i < XLEN; i++) begin
      load_ext[i] = (i < nbits) ? rsp_shift[i] : sign_bit;
    end
    rsp_rdata = (mem_rsp_err_i || wen_q) ? '0 : load_ext;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = illegal ? S_RESP : S_REQ;
      S_REQ:   if (mem_req_ready_i) state_d = S_WAIT;
      S_WAIT:  if (mem_rsp_valid_i) state_d = S_RESP;
      default: if (resp_ready_i) state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      wen_q    <= 1'b0;
      signed_q <= 1'b0;
      size_q   <= 2'd0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        wen_q    <= req_wen_i;
        signed_q <= req_signed_i;
        size_q   <= req_size_i;
        addr_q   <= req_addr_i;
        wdata_q  <= req_wdata_i;
      end
      if (rsp_take) begin
        rdata_q <= rsp_rdata;
        err_q   <= mem_rsp_err_i;
      end else if (accept && illegal) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lsu_core.sv
// Bench for lsu_core: an XLEN=32 and an XLEN=64 instance driven through one
// transaction task, checked against a behavioural model of the access rules.
module tb_lsu_core;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // index 0: XLEN=32 instance, index 1: XLEN=64 instance
  logic [1:0]       req_valid, req_wen, req_signed, resp_ready;
  logic [1:0]       mem_req_ready, mem_rsp_valid, mem_rsp_err;
  logic [1:0][1:0]  req_size;
  logic [1:0][31:0] req_addr;
  logic [1:0][63:0] req_wdata, mem_rsp_data;
  wire  [1:0]       req_ready, resp_valid, resp_err, mem_req_valid, mem_we;
  wire  [1:0][31:0] mem_addr;
  wire  [1:0][63:0] resp_rdata, mem_wdata;
  wire  [1:0][7:0]  mem_wstrb;
  wire  [1:0][1:0]  state;

  int n_chk = 0;
  int n_fail = 0;

  lsu_core #(.XLEN(32), .ADDR_W(32)) u_dut32 (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]), .req_wen_i(req_wen[0]),
    .req_size_i(req_size[0]), .req_signed_i(req_signed[0]), .req_addr_i(req_addr[0]),
    .req_wdata_i(req_wdata[0][31:0]),
    .resp_valid_o(resp_valid[0]), .resp_ready_i(resp_ready[0]),
    .resp_rdata_o(resp_rdata[0][31:0]), .resp_err_o(resp_err[0]),
    .mem_req_valid_o(mem_req_valid[0]), .mem_req_ready_i(mem_req_ready[0]),
    .mem_we_o(mem_we[0]), .mem_addr_o(mem_addr[0]), .mem_wdata_o(mem_wdata[0][31:0]),
    .mem_wstrb_o(mem_wstrb[0][3:0]),
    .mem_rsp_valid_i(mem_rsp_valid[0]), .mem_rsp_data_i(mem_rsp_data[0][31:0]),
    .mem_rsp_err_i(mem_rsp_err[0]), .state_o(state[0])
  );
  assign resp_rdata[0][63:32] = '0;
  assign mem_wdata[0][63:32]  = '0;
  assign mem_wstrb[0][7:4]    = '0;

  lsu_core #(.XLEN(64), .ADDR_W(32)) u_dut64 (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]), .req_wen_i(req_wen[1]),
    .req_size_i(req_size[1]), .req_signed_i(req_signed[1]), .req_addr_i(req_addr[1]),
    .req_wdata_i(req_wdata[1]),
    .resp_valid_o(resp_valid[1]), .resp_ready_i(resp_ready[1]),
    .resp_rdata_o(resp_rdata[1]), .resp_err_o(resp_err[1]),
    .mem_req_valid_o(mem_req_valid[1]), .mem_req_ready_i(mem_req_ready[1]),
    .mem_we_o(mem_we[1]), .mem_addr_o(mem_addr[1]), .mem_wdata_o(mem_wdata[1]),
    .mem_wstrb_o(mem_wstrb[1]),
    .mem_rsp_valid_i(mem_rsp_valid[1]), .mem_rsp_data_i(mem_rsp_data[1]),
    .mem_rsp_err_i(mem_rsp_err[1]), .state_o(state[1])
  );

  // Load result from the architectural rule: shift, keep 8<<size bits, extend.
  function automatic logic [63:0] exp_load(input int xl, input logic [63:0] d,
                                           input int off, input int size, input bit sgn);
    logic [63:0] v;
    int nb;
    nb = 8 << size;
    v = d >> (8 * off);
    if (nb < 64) begin
      v = v & ((64'd1 << nb) - 64'd1);
      if (sgn && v[nb-1]) v = v | ~((64'd1 << nb) - 64'd1);
    end
    if (xl == 32) v = v & 64'hFFFF_FFFF;
    return v;
  endfunction

  task automatic run_txn(input int u, input bit wen, input int size, input bit sgn,
                         input logic [31:0] addr, input logic [63:0] wd, input logic [63:0] rd,
                         input bit berr, input int rq_st, input int rs_dl, input int rp_st,
                         input string nm);
    int xl, off;
    bit ill, e_err;
    logic [63:0] xm, e_rd, e_wd;
    logic [31:0] e_ad;
    logic [7:0]  e_st;
    xl    = (u == 1) ? 64 : 32;
    xm    = (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF;
    off   = int'(addr % (xl / 8));
    ill   = ((addr % (32'd1 << size)) != 0) || (size == 3 && xl == 32);
    e_ad  = addr & ~(32'(xl / 8) - 32'd1);
    e_wd  = (wd << (8 * off)) & xm;
    e_st  = wen ? 8'(((64'd1 << (1 << size)) - 64'd1) << off) : 8'h00;
    e_err = ill || berr;
    e_rd  = (e_err || wen) ? 64'd0 : exp_load(xl, rd & xm, off, size, sgn);

    for (int k = 0; k < 20 && req_ready[u] !== 1'b1; k++) begin
      @(posedge clk); #1;
    end
    n_chk++;
    if (req_ready[u] !== 1'b1) begin
      n_fail++; $display("FAIL %s req_ready got %b exp 1", nm, req_ready[u]);
    end
    req_valid[u] = 1'b1; req_wen[u] = wen; req_size[u] = 2'(size);
    req_signed[u] = sgn; req_addr[u] = addr; req_wdata[u] = wd;
    @(posedge clk); #1;
    req_valid[u] = 1'b0; req_wdata[u] = {$urandom, $urandom}; req_addr[u] = $urandom;

    if (ill) begin
      n_chk++;
      if (mem_req_valid[u] !== 1'b0) begin
        n_fail++; $display("FAIL %s illegal mem_req_valid got %b exp 0", nm, mem_req_valid[u]);
      end
    end else begin
      for (int i = 0; i <= rq_st; i++) begin
        n_chk++;
        if (mem_req_valid[u] !== 1'b1 || mem_we[u] !== wen || mem_addr[u] !== e_ad ||
            mem_wdata[u] !== e_wd || mem_wstrb[u] !== e_st) begin
          n_fail++;
          $display("FAIL %s bus_req got v=%b we=%b a=%h d=%h s=%h exp v=1 we=%b a=%h d=%h s=%h",
                   nm, mem_req_valid[u], mem_we[u], mem_addr[u], mem_wdata[u], mem_wstrb[u],
                   wen, e_ad, e_wd, e_st);
        end
        n_chk++;
        if (resp_valid[u] !== 1'b0 || req_ready[u] !== 1'b0) begin
          n_fail++; $display("FAIL %s req_phase resp_valid/req_ready got %b%b exp 00",
                             nm, resp_valid[u], req_ready[u]);
        end
        mem_req_ready[u] = (i == rq_st);
        @(posedge clk); #1;
      end
      mem_req_ready[u] = 1'b0;
      for (int i = 0; i <= rs_dl; i++) begin
        n_chk++;
        if (mem_req_valid[u] !== 1'b0 || resp_valid[u] !== 1'b0) begin
          n_fail++; $display("FAIL %s wait_phase mem_req_valid/resp_valid got %b%b exp 00",
                             nm, mem_req_valid[u], resp_valid[u]);
        end
        if (i == rs_dl) begin
          mem_rsp_valid[u] = 1'b1; mem_rsp_data[u] = rd; mem_rsp_err[u] = berr;
        end else begin
          mem_rsp_data[u] = {$urandom, $urandom}; mem_rsp_err[u] = 1'b1;
        end
        @(posedge clk); #1;
      end
      mem_rsp_valid[u] = 1'b0; mem_rsp_err[u] = 1'b0; mem_rsp_data[u] = {$urandom, $urandom};
    end

    for (int i = 0; i <= rp_st; i++) begin
      n_chk++;
      if (resp_valid[u] !== 1'b1 || resp_err[u] !== e_err || (resp_rdata[u] & xm) !== e_rd) begin
        n_fail++;
        $display("FAIL %s resp got v=%b err=%b rdata=%h exp v=1 err=%b rdata=%h",
                 nm, resp_valid[u], resp_err[u], resp_rdata[u], e_err, e_rd);
      end
      n_chk++;
      if (req_ready[u] !== 1'b0 || mem_req_valid[u] !== 1'b0) begin
        n_fail++; $display("FAIL %s resp_phase req_ready/mem_req_valid got %b%b exp 00",
                           nm, req_ready[u], mem_req_valid[u]);
      end
      resp_ready[u] = (i == rp_st);
      @(posedge clk); #1;
    end
    resp_ready[u] = 1'b0;
    n_chk++;
    if (resp_valid[u] !== 1'b0 || req_ready[u] !== 1'b1) begin
      n_fail++; $display("FAIL %s after_resp resp_valid/req_ready got %b%b exp 01",
                         nm, resp_valid[u], req_ready[u]);
    end
  endtask

  task automatic test_reset();
    for (int u = 0; u < 2; u++) begin
      n_chk++;
      if ({req_ready[u], mem_req_valid[u], resp_valid[u], resp_err[u], mem_wstrb[u],
           resp_rdata[u], state[u]} !== '0) begin
        n_fail++; $display("FAIL reset_u%0d rdy=%b mrv=%b rv=%b err=%b strb=%h rd=%h st=%0d exp all 0",
                           u, req_ready[u], mem_req_valid[u], resp_valid[u], resp_err[u],
                           mem_wstrb[u], resp_rdata[u], state[u]);
      end
    end
  endtask

  task automatic test_load_store();
    run_txn(0, 0, 0, 1, 32'h8000_0003, 64'h0, 64'h80AA_BBCC, 0, 0, 0, 0, "lb_signed");
    run_txn(0, 1, 1, 0, 32'h8000_0002, 64'h1234_ABCD, 64'h0, 0, 0, 0, 0, "sh_upper");
    run_txn(0, 0, 2, 0, 32'h8000_0008, 64'h0, 64'hCAFE_F00D, 0, 0, 0, 0, "lw_full_width");
    run_txn(0, 0, 1, 1, 32'h8000_0000, 64'h0, 64'h1234_8001, 0, 0, 0, 0, "lh_signed_low");
  endtask

  task automatic test_misaligned();
    run_txn(0, 0, 2, 0, 32'h8000_0001, 64'h0, 64'h0, 0, 0, 0, 0, "lw_misaligned");
    run_txn(0, 0, 3, 0, 32'h8000_0000, 64'h0, 64'h0, 0, 0, 0, 0, "ld_on_xlen32");
    run_txn(0, 1, 1, 0, 32'h8000_0003, 64'hFFFF, 64'h0, 0, 0, 0, 0, "sh_misaligned");
  endtask

  task automatic test_backpressure();
    run_txn(0, 1, 0, 0, 32'h8000_0005, 64'h0000_00A5, 64'h0, 0, 4, 3, 2, "sb_backpressure");
    run_txn(0, 0, 0, 0, 32'h8000_0006, 64'h0, 64'h1122_3344, 0, 4, 3, 2, "lbu_backpressure");
  endtask

  task automatic test_xlen64();
    run_txn(1, 0, 2, 0, 32'h8000_0004, 64'h0, 64'hDEAD_BEEF_0123_4567, 0, 0, 0, 0, "lwu64_off4");
    run_txn(1, 0, 3, 0, 32'h8000_0008, 64'h0, 64'h5555_6666_7777_8888, 1, 0, 1, 0, "ld64_bus_err");
    run_txn(1, 1, 3, 0, 32'h8000_0010, 64'h0102_0304_0506_0708, 64'h0, 0, 0, 0, 0, "sd64");
    run_txn(1, 0, 3, 0, 32'h8000_0018, 64'h0, 64'hFEDC_BA98_7654_3210, 0, 0, 0, 0, "ld64_full");
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      int u, size;
      logic [31:0] addr;
      u = $urandom_range(0, 1);
      size = $urandom_range(0, 3);
      addr = $urandom;
      if ($urandom_range(0, 9) < 7) addr = addr & ~((32'd1 << size) - 32'd1);
      run_txn(u, 1'($urandom_range(0, 1)), size, 1'($urandom_range(0, 1)), addr,
              {$urandom, $urandom}, {$urandom, $urandom}, ($urandom_range(0, 7) == 0),
              $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2), "random");
    end
  endtask

  task automatic test_reset_mid_access();
    req_valid[0] = 1'b1; req_wen[0] = 1'b1; req_size[0] = 2'd2; req_signed[0] = 1'b0;
    req_addr[0] = 32'h8000_0010; req_wdata[0] = 64'hAAAA_5555;
    @(posedge clk); #1;
    req_valid[0] = 1'b0; mem_req_ready[0] = 1'b1;
    @(posedge clk); #1;
    mem_req_ready[0] = 1'b0;
    n_chk++;
    if (mem_req_valid[0] !== 1'b0 || resp_valid[0] !== 1'b0 || mem_wstrb[0] !== 8'h0F) begin
      n_fail++; $display("FAIL mid_reset_setup mrv=%b rv=%b strb=%h exp 0 0 0f",
                         mem_req_valid[0], resp_valid[0], mem_wstrb[0]);
    end
    rst_n = 1'b0;
    #1;
    test_reset();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    mem_rsp_valid[0] = 1'b1; mem_rsp_data[0] = 64'hFFFF_FFFF; mem_rsp_err[0] = 1'b1;
    @(posedge clk); #1;
    mem_rsp_valid[0] = 1'b0; mem_rsp_err[0] = 1'b0;
    n_chk++;
    if (resp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1 || resp_err[0] !== 1'b0 ||
        resp_rdata[0] !== 64'd0 || state[0] !== 2'd0) begin
      n_fail++; $display("FAIL stray_rsp_idle rv=%b rdy=%b err=%b rd=%h st=%0d exp 0 1 0 0 0",
                         resp_valid[0], req_ready[0], resp_err[0], resp_rdata[0], state[0]);
    end
    run_txn(0, 0, 1, 0, 32'h8000_0022, 64'h0, 64'hBEEF_0000, 0, 0, 0, 0, "load_after_reset");
  endtask

  initial begin
    req_valid = '0; req_wen = '0; req_signed = '0; resp_ready = '0;
    mem_req_ready = '0; mem_rsp_valid = '0; mem_rsp_err = '0;
    req_size = '0; req_addr = '0; req_wdata = '0; mem_rsp_data = '0;
    #2;
    test_reset();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_load_store();
    test_misaligned();
    test_backpressure();
    test_xlen64();
    test_random();
    test_reset_mid_access();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_core.md
# lsu_core

Parametrised load/store unit that replaces the combinational DPI memory access in the single-cycle core with a registered, handshaked data-memory port. It sits between the execute stage, which supplies the ALU-computed address and store data, and a simple valid/ready memory bus. It generates byte strobes, shifts store data into lane position, extracts and sign/zero-extends load data, and flags misaligned accesses and bus errors. One access is outstanding at a time.

## Interface
- XLEN, 32: data width, 32 or 64; bus width equals XLEN
- ADDR_W, 32: address width
- OFF_W, $clog2(XLEN/8): byte-offset bits (derived, not overridden)

- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- req_valid  in  1  execute stage presents an access
- req_ready  out  1  LSU can accept; equals (state==IDLE) && rst
- req_wen  in  1  1 store, 0 load
- req_size  in  2  0 byte, 1 half, 2 word, 3 dword (legal only when XLEN=64)
- req_signed  in  1  loads: sign-extend when 1, zero-extend when 0
- req_addr  in  ADDR_W  byte address
- req_wdata  in  XLEN  store data, right-aligned
- resp_valid  out  1  result available
- resp_ready  in  1  consumer accepts result
- resp_rdata  out  XLEN  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned, illegal size, or bus error
- mem_req_valid  out  1  bus request
- mem_req_ready  in  1  bus accepts request
- mem_we  out  1  bus write
- mem_addr  out  ADDR_W  req_addr with low OFF_W bits cleared
- mem_wdata  out  XLEN  req_wdata << (8*offset)
- mem_wstrb  out  XLEN/8  ((1<<(1<<size))-1) << offset; all zero on reads
- mem_rsp_valid  in  1  bus response, single cycle, no backpressure
- mem_rsp_data  in  XLEN  full bus word read
- mem_rsp_err  in  1  bus error with response

## Operation
- States: IDLE, REQ, WAIT, RESP.
- IDLE: on req_valid && req_ready, register wen, size, signed, addr, wdata. Illegal access goes to RESP with resp_err=1 and no bus traffic. Illegal means addr not a multiple of 1<<size, or size 3 with XLEN=32. A legal access goes to REQ.
- REQ: mem_req_valid=1 with stable mem_we/addr/wdata/wstrb until mem_req_ready; then WAIT.
- WAIT: on mem_rsp_valid go to RESP. Latch err=mem_rsp_err and data:
  - loads: (mem_rsp_data >> 8*offset) truncated to 8<<size bits, then extended to XLEN per signed flag
  - stores: data 0
  - error: data 0
- RESP: resp_valid=1 with stable rdata/err until resp_ready; then IDLE.
- A full-width access (size = log2(XLEN/8)) with signed=0 returns the word unchanged.
- mem_rsp_valid outside WAIT is ignored and dropped.
- Reset values: state IDLE, mem_req_valid 0, resp_valid 0, resp_rdata 0, resp_err 0, mem_wstrb 0. req_ready is 0 while rst low.
- Reset mid-access: immediate return to IDLE and the outstanding transaction is abandoned. The memory side is reset by the same rst.

## Timing
- Accept at cycle T. mem_req_valid rises at T+1 (registered).
- Bus handshake at T+1 at the earliest. mem_rsp_valid is legal from the cycle after the handshake (T+2 earliest).
- resp_valid rises the cycle after mem_rsp_valid. Minimum load/store latency from accept to resp_valid is 3 cycles.
- Illegal access: resp_valid at T+1.
- The next request can be accepted in the cycle after the resp handshake; req_ready is never 1 in the same cycle as resp_valid.
- All outputs are driven from registers or state only; there are no combinational paths from inputs to outputs except req_ready on rst.

## Test plan
- XLEN=32, load byte signed at addr 0x80000003, bus returns 0x80AABBCC -> resp_rdata 0xFFFFFF80, resp_err 0, mem_addr 0x80000000, mem_wstrb 0; resp_valid exactly 3 cycles after accept when mem_req_ready=1 and response comes 1 cycle later.
- Store half 0x1234ABCD at 0x80000002 -> mem_wdata 0xABCD0000, mem_wstrb 4'b1100, mem_we 1; resp_rdata 0, resp_err 0.
- Misaligned word load at 0x80000001 -> no mem_req_valid, resp_valid at T+1, resp_err 1, rdata 0; same for size 3 at XLEN=32.
- Backpressure: mem_req_ready low 4 cycles, response after 3 more, resp_ready low 2 cycles -> request fields and response fields held stable throughout; req_ready 0 until resp handshake.
- XLEN=64, load word unsigned at offset 4 of 0xDEADBEEF_01234567 -> resp_rdata 0x00000000_DEADBEEF; mem_rsp_err=1 on another load -> resp_err 1, rdata 0.
- Assert rst low in WAIT, then release and issue a new load -> all outputs at reset values immediately; a stray mem_rsp_valid in IDLE is ignored; the new load completes normally.
